uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 monitor receiver on the MicroBlaze UART
//  path. Supports configurable data width, parity and stop bits. Synchronises rxd, detects frame
//  and parity errors, and buffers received words in a small FIFO. Output is a valid/ready
//  handshake, consumed by the testbench console writer or an AXI-side bridge.
// PARAMETERS
//  CLK_FREQ    100000000  system clock frequency, Hz
//  BAUD        230400     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at defaults)
//  DATA_BITS   8          data bits per frame, legal range 5..9
//  PARITY      0          0 = none, 1 = even, 2 = odd
//  STOP_BITS   1          1 or 2
//  FIFO_DEPTH  4          receive buffer entries; power of two, >= 2
// PORTS
//  clock          in   1          system clock, rising edge
//  reset_rtl      in   1          asynchronous, active-low reset
//  uart_rtl_rxd   in   1          serial line, idle high; asynchronous to clock
//  rx_data        out  DATA_BITS  FIFO head word, LSB = first bit received
//  rx_parity_err  out  1          parity error flag of the head word
//  rx_frame_err   out  1          stop-bit error flag of the head word
//  rx_valid       out  1          FIFO not empty
//  rx_ready       in   1          consumer accepts the head word when rx_valid & rx_ready
//  rx_overrun     out  1          one-cycle pulse: a frame completed while the FIFO was full
//  rx_busy        out  1          1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM in IDLE; synchroniser flops preset to 1.
//  rxd passes through a 2-flop synchroniser; all FSM decisions use the synchronised signal rxs.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//   IDLE: rxs == 0 -> START, with the bit counter cleared.
//   START: at cnt == (CLKS_PER_BIT-1)/2, rxs == 0 -> DATA (cnt cleared); rxs == 1 -> IDLE (glitch).
//   DATA: every CLKS_PER_BIT cycles, sample one bit LSB-first; after DATA_BITS samples -> PARITY,
//    or -> STOP when PARITY == 0.
//   PARITY: sample one bit; parity_err = (XOR of data bits ^ sample) != (PARITY == 2).
//   STOP: sample each stop bit. A 0 on any stop bit sets frame_err. After the last stop sample,
//    push {frame_err, parity_err, data}; go to IDLE if the sample was 1, else to WAIT_IDLE.
//    The FSM leaves at mid-stop-bit so back-to-back frames are not lost.
//   WAIT_IDLE: hold until rxs == 1 (covers break conditions), then -> IDLE. No push in this state.
//  Push/pop: push occurs in the cycle the last stop bit is sampled. rx_valid rises on the next
//   cycle. Pop occurs when rx_valid & rx_ready. Push and pop on the same cycle with the FIFO full
//   are both accepted; no overrun.
//  Full FIFO, push without pop: the new word is dropped, rx_overrun pulses for 1 cycle, and stored
//   words are untouched.
//  Latency from the line's mid-last-stop-bit to rx_valid: 2 synchroniser cycles + 1 cycle.
//  Counters: cnt width = $clog2(CLKS_PER_BIT); bit index width = 4. FIFO pointers use one extra
//   wrap bit for full/empty detection.
//  Reset asserted mid-frame: FSM and FIFO clear immediately. The partial frame is discarded, and
//   after release the receiver resynchronises on the next falling edge.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: every sample point (start, data, parity, stop) takes a 2-of-3
//   majority of rxs at cnt = mid-1, mid, mid+1. The decision lands 1 cycle later than without the
//   macro, and all following sample points shift by the same 1 cycle.
//  UART_RX_MAJORITY_EN undefined: a single sample of rxs at mid.
// STRUCTURE
//  uart_pkg: FSM state localparams; parity mode codes PAR_NONE/PAR_EVEN/PAR_ODD; function
//   clks_per_bit(freq, baud).
//  Sub-module uart_rx_fifo: synchronous FIFO, width DATA_BITS+2, depth FIFO_DEPTH, with
//   show-ahead output.
// TESTING (CLK_FREQ 100 MHz, BAUD 230400, 434 clocks per bit)
//  1. 8N1, send 0x41, 0x0A back-to-back with 1 stop bit -> two pops with rx_data 0x41 then 0x0A;
//     both error flags 0.
//  2. DATA_BITS=7, PARITY=2: send 0x35 with a correct odd parity bit, then with an inverted parity
//     bit -> rx_parity_err 0, then 1; rx_data 0x35 both times.
//  3. Stop bit driven 0, line held low for 20 bit times -> one word with rx_frame_err = 1; FSM in
//     WAIT_IDLE until the line returns high; no second word.
//  4. rx_ready held 0, send 5 frames with FIFO_DEPTH=4 -> rx_overrun pulses once, on frame 5;
//     pops then return frames 1..4 in order.
//  5. 150-cycle low glitch on an idle line -> no push; rx_busy returns to 0 by cycle 220.
//  6. reset_rtl pulsed low during DATA of frame 1, frame 2 sent after release -> only frame 2 is
//     received. With UART_RX_MAJORITY_EN, one-cycle spikes at mid-bit are rejected.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART receiver: FSM state codes, parity modes
// and the bit-period helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO with show-ahead head word; a push into a full FIFO
// is dropped (unless a pop frees the slot in the same cycle) and flagged for one cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_rtl,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overrun_q, overrun_d;
  logic             empty, full, do_push, do_pop;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overrun_d = push && !do_push;
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign head    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign valid   = !empty;
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, parity, stop bits) with a receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 230400,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_rtl,
  input  logic                 uart_rtl_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DELAY = 1;
`else
  localparam int MAJ_DELAY = 0;
`endif
  localparam logic [CNT_W-1:0] START_PT = CNT_W'((CPB - 1) / 2 + MAJ_DELAY);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CPB - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  logic                 rxs;
  logic                 bit_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 push;
  logic                 push_frm;
  logic [DATA_BITS+1:0] head;

  always_comb begin
    sync_d = {sync_q[0], uart_rtl_rxd};
  end
  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Holds rxs from the two cycles before the decision; the current rxs is the third vote.
  logic [1:0] maj_q, maj_d;
  always_comb begin
    maj_d = {maj_q[0], rxs};
    bit_s = (maj_q[1] & maj_q[0]) | (maj_q[1] & rxs) | (maj_q[0] & rxs);
  end
  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) maj_q <= 2'b11;
    else            maj_q <= maj_d;
  end
`else
  always_comb begin
    bit_s = rxs;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    push      = 1'b0;
    push_frm  = frm_err_q | ~bit_s;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == START_PT) begin
          cnt_d   = '0;
          state_d = bit_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = ((^shreg_q) ^ bit_s) != (PARITY == PAR_ODD);
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          idx_d     = idx_q + 4'd1;
          frm_err_d = push_frm;
          // Leave at mid-stop-bit so an immediately following start edge is caught.
          if (idx_q == STOP_LAST) begin
            push    = 1'b1;
            state_d = bit_s ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      sync_q    <= 2'b11;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_rtl (reset_rtl),
    .push      (push),
    .push_data ({push_frm, par_err_q, shreg_q}),
    .pop       (rx_ready),
    .head      (head),
    .valid     (rx_valid),
    .overrun   (rx_overrun)
  );

  assign rx_data       = head[DATA_BITS-1:0];
  assign rx_parity_err = head[DATA_BITS];
  assign rx_frame_err  = head[DATA_BITS+1];
  assign rx_busy       = (state_q != ST_IDLE);

endmodule
